// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues reads to a 1-cycle synchronous instruction
// memory and presents {pc, inst} to decode, with stall hold, redirect and squash handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        pc_misaligned
);

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  logic [31:0] fetch_pc;
  logic        pend;
  logic [31:0] pend_pc;
  logic        hold_v;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;
  logic        issue;
  logic        capture;

  // Issue stage: fetch_pc goes straight to memory whenever decode can accept
  always_comb begin
    issue     = !rst && !stall;
    imem_en   = issue;
    imem_addr = fetch_pc;
    // A word returning into a stalled decode is parked once; later stall cycles keep it
    capture   = !rst && !redirect_valid && stall && pend && !hold_v;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc      <= align_word(RESET_PC);
      pend          <= 1'b0;
      hold_v        <= 1'b0;
      pc_misaligned <= 1'b0;
    end else begin
      pc_misaligned <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (redirect_valid) begin
        fetch_pc <= align_word(redirect_pc);
        pend     <= 1'b0;
        hold_v   <= 1'b0;
      end else if (!stall) begin
        fetch_pc <= fetch_pc + 32'd4;
        pend     <= 1'b1;
        hold_v   <= 1'b0;
      end else begin
        pend <= 1'b0;
        if (capture) hold_v <= 1'b1;
      end
    end
  end

  // Data-only registers; their validity is tracked by pend / hold_v
  always_ff @(posedge clk) begin
    if (issue && !redirect_valid) pend_pc <= fetch_pc;
    if (capture) begin
      hold_pc   <= pend_pc;
      hold_inst <= imem_rdata;
    end
  end

  // Present stage: held word wins, then the word returning from memory, else a bubble
  always_comb begin
    if_valid = 1'b0;
    if_pc    = fetch_pc;
    if_inst  = NOP_INST;
    if (rst) begin
      if_pc = RESET_PC;
    end else if (hold_v) begin
      if_valid = 1'b1;
      if_pc    = hold_pc;
      if_inst  = hold_inst;
    end else if (pend) begin
      if_valid = 1'b1;
      if_pc    = pend_pc;
      if_inst  = imem_rdata;
    end
  end

endmodule
